ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
- Hazard and forwarding controller for the EX stage of the 5-stage 16-bit pipeline.
- Tracks the register destinations of the instructions currently in EX, MEM and WB in an internal shadow pipeline.
- Drives the EX operand forwarding mux selects, and detects load-use hazards that need a stall plus bubble.
- Handles branch flush bubbles and global freezes during multi-cycle memory accesses.

Parameters:
- REG_BITS, 4: register specifier width (16 architectural registers, R0 hardwired zero)
- CNT_BITS, 16: width of the load-use stall counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  REG_BITS  ID source A register
- id_rt  in  REG_BITS  ID source B register
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_rd  in  REG_BITS  ID destination register (already muxed by regDst)
- id_reg_write  in  1  instruction writes the register file
- id_mem_read  in  1  instruction is a load
- flush  in  1  branch taken; ID instruction is wrong-path
- mem_wait  in  1  data memory busy; whole pipeline frozen
- forward_a  out  2  EX operand A select: 10 = EX/MEM ALU result, 01 = WB data, 00 = register file
- forward_b  out  2  EX operand B select, same encoding
- stall_id  out  1  hold PC and IF/ID register
- ex_bubble  out  1  load NOP into ID/EX instead of the ID instruction
- stall_count  out  CNT_BITS  number of load-use stall cycles

Behaviour:
- Internal entries EX, MEM, WB.
  - Each entry holds: valid, dst, reg_write, mem_read.
  - The EX entry also holds rs, rt, uses_rs, uses_rt.
- Reset (asynchronous): all entries invalid with all fields 0; stall_count = 0; all outputs 0.
- Load-use hazard (lu), combinational:
  - Condition: id_valid & EX.valid & EX.mem_read & EX.reg_write & EX.dst != 0 & ((id_uses_rs & id_rs == EX.dst) | (id_uses_rt & id_rt == EX.dst)).
- Priority per cycle: mem_wait > flush > lu > normal.
  - mem_wait = 1: all entries hold; stall_id = 1; ex_bubble = 0; stall_count holds.
  - flush = 1: EX <= bubble (valid = 0); MEM <= EX; WB <= MEM; stall_id = 0; ex_bubble = 1. lu is ignored.
  - lu = 1: EX <= bubble; MEM <= EX; WB <= MEM; stall_id = 1; ex_bubble = 1; stall_count += 1, saturating at all-ones.
  - Normal: EX <= ID fields with valid = id_valid; MEM <= EX; WB <= MEM; stall_id = 0; ex_bubble = 0.
- Forwarding, combinational from the registered entries, evaluated for each EX source (shown for A; B is identical using rt/uses_rt):
  - 10 if EX.valid & EX.uses_rs & MEM.valid & MEM.reg_write & !MEM.mem_read & MEM.dst != 0 & MEM.dst == EX.rs.
  - Otherwise 01 if EX.valid & EX.uses_rs & WB.valid & WB.reg_write & WB.dst != 0 & WB.dst == EX.rs.
  - Otherwise 00.
  - MEM has priority over WB (youngest producer wins).
- A load sitting in MEM is never forwarded from MEM; the lu stall guarantees it reaches WB before it is needed.
- ID reads of a register being written in WB rely on register file write-through; this block takes no action for them.
- Forward outputs are a pure function of state, so they stay stable during mem_wait.
- Latency: a producer is forwardable on the first cycle its consumer occupies EX. There is no extra delay beyond the single lu bubble.

Test Plan:
- Back-to-back ALU: ADD R3 (dst 3) then SUB using rs = 3 -> on SUB's EX cycle forward_a = 10, stall_id = 0.
- Distance 2: ADD R3, NOP, XOR rt = 3 -> forward_b = 01; with ADD R3 then ADD R3 then use R3 -> forward_a = 10 (MEM priority).
- Load-use: LW R5 then ADD rs = 5 -> exactly one cycle stall_id = 1 and ex_bubble = 1, stall_count 0 -> 1; next cycle forward_a = 01.
- R0 and unused operands: producer dst = 0, or consumer uses_rs = 0 with a matching rs -> forward_a = 00, no stall.
- Freeze and flush: assert mem_wait for 3 cycles during a load-use -> entries and forwards hold, stall_count unchanged, stall_id = 1; flush with lu -> ex_bubble = 1, stall_id = 0, stall_count unchanged.
- Reset mid-stream: assert rst during a lu stall -> outputs immediately 0, stall_count = 0; a previously pending producer is not forwarded after release.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX-stage forwarding selects, load-use stall and flush/freeze bubble control
module ex_hazard_ctrl #(
   parameter int REG_BITS = 4,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_BITS-1:0] id_rs,
   input  logic [REG_BITS-1:0] id_rt,
   input  logic                id_uses_rs,
   input  logic                id_uses_rt,
   input  logic [REG_BITS-1:0] id_rd,
   input  logic                id_reg_write,
   input  logic                id_mem_read,
   input  logic                flush,
   input  logic                mem_wait,
   output logic [1:0]          forward_a,
   output logic [1:0]          forward_b,
   output logic                stall_id,
   output logic                ex_bubble,
   output logic [CNT_BITS-1:0] stall_count
);
   logic                ex_valid, ex_reg_write, ex_mem_read, ex_uses_rs, ex_uses_rt;
   logic [REG_BITS-1:0] ex_dst, ex_rs, ex_rt;
   logic                mem_valid, mem_reg_write, mem_mem_read;
   logic [REG_BITS-1:0] mem_dst;
   logic                wb_valid, wb_reg_write;
   logic [REG_BITS-1:0] wb_dst;
   logic                lu, insert_bubble;

   function automatic logic [1:0] fwd_sel(input logic uses, input logic [REG_BITS-1:0] src);
      if (ex_valid && uses && mem_valid && mem_reg_write && !mem_mem_read && mem_dst != '0 && mem_dst == src)
         return 2'b10;
      if (ex_valid && uses && wb_valid && wb_reg_write && wb_dst != '0 && wb_dst == src)
         return 2'b01;
      return 2'b00;
   endfunction

   // Hazard detection, bubble decision and forwarding selects; reset forces all controls low
   always_comb begin
      lu = id_valid && ex_valid && ex_mem_read && ex_reg_write && ex_dst != '0 &&
           ((id_uses_rs && id_rs == ex_dst) || (id_uses_rt && id_rt == ex_dst));
      insert_bubble = flush || lu;
      stall_id  = !rst && (mem_wait || (!flush && lu));
      ex_bubble = !rst && !mem_wait && insert_bubble;
      forward_a = fwd_sel(ex_uses_rs, ex_rs);
      forward_b = fwd_sel(ex_uses_rt, ex_rt);
   end

   // Shadow pipeline advance (held on freeze) and saturating load-use stall counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {ex_valid, ex_reg_write, ex_mem_read, ex_uses_rs, ex_uses_rt} <= '0;
         {ex_dst, ex_rs, ex_rt} <= '0;
         {mem_valid, mem_reg_write, mem_mem_read, mem_dst} <= '0;
         {wb_valid, wb_reg_write, wb_dst} <= '0;
         stall_count <= '0;
      end else if (!mem_wait) begin
         {wb_valid, wb_reg_write, wb_dst} <= {mem_valid, mem_reg_write, mem_dst};
         {mem_valid, mem_reg_write, mem_mem_read, mem_dst} <= {ex_valid, ex_reg_write, ex_mem_read, ex_dst};
         if (insert_bubble) begin
            {ex_valid, ex_reg_write, ex_mem_read, ex_uses_rs, ex_uses_rt} <= '0;
            {ex_dst, ex_rs, ex_rt} <= '0;
         end else begin
            {ex_valid, ex_reg_write, ex_mem_read, ex_uses_rs, ex_uses_rt} <=
               {id_valid, id_reg_write, id_mem_read, id_uses_rs, id_uses_rt};
            {ex_dst, ex_rs, ex_rt} <= {id_rd, id_rs, id_rt};
         end
         if (!flush && lu && stall_count != '1)
            stall_count <= stall_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: directed-vector self-checking bench for ex_hazard_ctrl
module tb_ex_hazard_ctrl;
   logic        clk = 0, rst = 0;
   logic        id_valid = 0, id_uses_rs = 0, id_uses_rt = 0, id_reg_write = 0, id_mem_read = 0;
   logic [3:0]  id_rs = 0, id_rt = 0, id_rd = 0;
   logic        flush = 0, mem_wait = 0;
   logic [1:0]  forward_a, forward_b;
   logic        stall_id, ex_bubble;
   logic [15:0] stall_count;
   int          checks = 0, errors = 0;

   ex_hazard_ctrl dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .mem_wait(mem_wait), .forward_a(forward_a), .forward_b(forward_b),
      .stall_id(stall_id), .ex_bubble(ex_bubble), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] rs, input logic urs, input logic [3:0] rt,
                        input logic urt, input logic [3:0] rd, input logic rw, input logic mr);
      id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
      id_rd = rd; id_reg_write = rw; id_mem_read = mr;
      #1;
   endtask

   task automatic nop();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drain();
      nop();
      repeat (3) tick();
   endtask

   initial begin
      rst = 1;
      #12;
      check("reset_fa", forward_a, 0);
      check("reset_fb", forward_b, 0);
      check("reset_stall", stall_id, 0);
      check("reset_bubble", ex_bubble, 0);
      check("reset_count", stall_count, 0);
      @(negedge clk);
      rst = 0;
      tick();

      // back-to-back ALU forwarding from MEM
      drive(1, 1, 1, 2, 1, 3, 1, 0);
      tick();
      drive(1, 3, 1, 4, 1, 11, 1, 0);
      check("b2b_stall", stall_id, 0);
      tick();
      check("b2b_fa", forward_a, 2);
      check("b2b_fb", forward_b, 0);

      // distance-2 forwarding from WB
      drive(1, 1, 1, 2, 1, 3, 1, 0);
      tick();
      nop();
      tick();
      drive(1, 1, 1, 3, 1, 7, 1, 0);
      tick();
      check("dist2_fb", forward_b, 1);
      check("dist2_fa", forward_a, 0);

      // MEM producer wins over WB producer
      drive(1, 1, 1, 2, 1, 3, 1, 0);
      tick();
      drive(1, 1, 1, 2, 1, 3, 1, 0);
      tick();
      drive(1, 3, 1, 0, 0, 10, 1, 0);
      tick();
      check("mem_prio_fa", forward_a, 2);
      drain();

      // load-use: one stall bubble, then forward from WB
      drive(1, 1, 1, 0, 0, 5, 1, 1);
      tick();
      drive(1, 5, 1, 0, 0, 12, 1, 0);
      check("lu_stall", stall_id, 1);
      check("lu_bubble", ex_bubble, 1);
      check("lu_count_before", stall_count, 0);
      tick();
      check("lu_count_after", stall_count, 1);
      check("lu_release_stall", stall_id, 0);
      check("lu_release_bubble", ex_bubble, 0);
      check("lu_fa_mem_load", forward_a, 0);
      tick();
      check("lu_fa_wb", forward_a, 1);
      drain();

      // R0 producer is never forwarded nor stalled on
      drive(1, 1, 1, 0, 0, 0, 1, 1);
      tick();
      drive(1, 0, 1, 0, 1, 13, 1, 0);
      check("r0_nostall", stall_id, 0);
      tick();
      check("r0_fa", forward_a, 0);
      check("r0_fb", forward_b, 0);

      // unused operand with matching register does not forward
      drive(1, 1, 1, 2, 1, 6, 1, 0);
      tick();
      drive(1, 6, 0, 0, 0, 14, 1, 0);
      tick();
      check("unused_fa", forward_a, 0);
      drain();

      // freeze during load-use: everything holds
      drive(1, 1, 1, 0, 0, 9, 1, 0);
      tick();
      drive(1, 9, 1, 0, 0, 5, 1, 1);
      tick();
      check("frz_pre_fa", forward_a, 2);
      drive(1, 5, 1, 0, 0, 12, 1, 0);
      mem_wait = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("frz_stall", stall_id, 1);
         check("frz_bubble", ex_bubble, 0);
         check("frz_fa", forward_a, 2);
         check("frz_count", stall_count, 1);
         tick();
      end
      mem_wait = 0;
      #1;
      check("frz_lu_stall", stall_id, 1);
      check("frz_lu_bubble", ex_bubble, 1);

      // flush overrides load-use
      flush = 1;
      #1;
      check("flush_bubble", ex_bubble, 1);
      check("flush_stall", stall_id, 0);
      tick();
      flush = 0;
      nop();
      check("flush_count", stall_count, 1);
      check("flush_fa", forward_a, 0);
      drain();

      // reset during a load-use stall
      drive(1, 1, 1, 0, 0, 5, 1, 1);
      tick();
      drive(1, 5, 1, 0, 0, 12, 1, 0);
      check("rst_pre_stall", stall_id, 1);
      rst = 1;
      #1;
      check("rst_stall", stall_id, 0);
      check("rst_bubble", ex_bubble, 0);
      check("rst_count", stall_count, 0);
      tick();
      rst = 0;
      #1;
      check("rst_post_stall", stall_id, 0);
      tick();
      check("rst_post_fa", forward_a, 0);
      check("rst_post_count", stall_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
